// File: rtl/axim_arb_pkg.sv
// Shared definitions for the AXI-master read arbiter.
//
// Contents:
//   arb_state_e       arbiter FSM state encoding (IDLE, START, XFER, DONE)
//   BYTES_PER_BEAT    bytes per stream beat for the default 32-bit data path
//   LOG2              log2(BYTES_PER_BEAT) for the default 32-bit data path
//   bytes_per_beat()  bytes per beat for an arbitrary data width
//
// The two constants describe the default build. The top derives its own
// values from C_M_AXI_DATA_WIDTH with bytes_per_beat() and $clog2, so other
// widths also work.
package axim_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_XFER  = 2'd2,
    ST_DONE  = 2'd3
  } arb_state_e;

  localparam int BYTES_PER_BEAT = 4;
  localparam int LOG2           = 2;

  function automatic int bytes_per_beat(input int data_width);
    return data_width / 8;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin selector.
//
// Ports:
//   req        in   NUM_REQ  pending requests
//   last_ptr   in   PTR_W    index of the most recently served requester
//   grant      out  NUM_REQ  one-hot grant (all zero when nothing is pending)
//   grant_idx  out  PTR_W    binary index of the granted requester
//
// The search starts at last_ptr+1 and wraps, so the requester that was just
// served has the lowest priority on the next round.
module rr_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   last_ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [PTR_W-1:0]   grant_idx
);

  always_comb begin
    int  idx;
    logic found;
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    idx       = 0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      // Wrap by subtraction: this works for any NUM_REQ, not just powers of two.
      idx = int'(last_ptr) + i;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = PTR_W'(idx);
      end
    end
  end

endmodule

// File: rtl/axim_rd_arbiter.sv
// Shares one AXI-master read engine (axim_ctrl) between NUM_REQ requesters.
//
// Ports:
//   clk, rst               clock and asynchronous active-high reset
//   req_valid_i/addr/size  per-requester read request (held until accepted)
//   req_ready_o            one-cycle pulse when a request is accepted
//   req_tvalid_o/tdata/
//   req_tlast_o/tready_i   read-data stream, routed to the granted requester
//   req_rdone_o            one-cycle pulse when the granted transfer completes
//   err_o                  sticky flag: beat count differed from the expected count
//   ctrl_rstart_o/raddr_offset_o/rxfer_size_o/rdone_i   axim_ctrl command side
//   rd_tvalid_i/tdata/tlast/tready_o                    axim_ctrl data stream
//
// Handshakes: a stream beat transfers on any rising edge where tvalid and
// tready are both high. tvalid does not depend on tready. Requests use a
// valid/accept pulse: req_valid_i stays high until req_ready_o pulses.
//
// Flow: IDLE (grant, latch) -> START (rstart pulse) -> XFER (stream routed,
// beats counted until ctrl_rdone_i) -> DONE (rdone pulse, error check) -> IDLE.
// Zero-byte requests skip XFER and never pulse ctrl_rstart_o.
module axim_rd_arbiter
  import axim_arb_pkg::*;
#(
  parameter int C_M_AXI_ADDR_WIDTH = 32,
  parameter int C_M_AXI_DATA_WIDTH = 32,
  parameter int C_XFER_SIZE_WIDTH  = 32,
  parameter int NUM_REQ            = 2
) (
  input  logic                                         clk,
  input  logic                                         rst,
  input  logic [NUM_REQ-1:0]                           req_valid_i,
  input  logic [NUM_REQ-1:0][C_M_AXI_ADDR_WIDTH-1:0]   req_addr_i,
  input  logic [NUM_REQ-1:0][C_XFER_SIZE_WIDTH-1:0]    req_size_i,
  output logic [NUM_REQ-1:0]                           req_ready_o,
  output logic [NUM_REQ-1:0]                           req_tvalid_o,
  output logic [C_M_AXI_DATA_WIDTH-1:0]                req_tdata_o,
  output logic                                         req_tlast_o,
  input  logic [NUM_REQ-1:0]                           req_tready_i,
  output logic [NUM_REQ-1:0]                           req_rdone_o,
  output logic                                         err_o,
  output logic                                         ctrl_rstart_o,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]                ctrl_raddr_offset_o,
  output logic [C_XFER_SIZE_WIDTH-1:0]                 ctrl_rxfer_size_o,
  input  logic                                         ctrl_rdone_i,
  input  logic                                         rd_tvalid_i,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]                rd_tdata_i,
  input  logic                                         rd_tlast_i,
  output logic                                         rd_tready_o
);

  localparam int XW       = C_XFER_SIZE_WIDTH;
  localparam int PTR_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int BPB      = bytes_per_beat(C_M_AXI_DATA_WIDTH);
  localparam int BPB_LOG2 = $clog2(BPB);
  localparam logic [XW-1:0] REM_MASK = XW'(BPB - 1);

  arb_state_e                  state_q, state_d;
  logic [PTR_W-1:0]            grant_q;
  logic [PTR_W-1:0]            rr_ptr_q;
  logic [C_M_AXI_ADDR_WIDTH-1:0] addr_q;
  logic [XW-1:0]               size_q;
  logic [XW:0]                 beat_cnt_q;
  logic [XW:0]                 exp_beats;
  logic                        err_q;

  logic [NUM_REQ-1:0]          arb_grant;
  logic [PTR_W-1:0]            arb_idx;
  logic [NUM_REQ-1:0]          ready_c;
  logic                        load;
  logic                        in_xfer;
  logic                        beat_fire;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_rr (
    .req       (req_valid_i),
    .last_ptr  (rr_ptr_q),
    .grant     (arb_grant),
    .grant_idx (arb_idx)
  );

  // ceil(size / BPB): whole beats from the shift, plus one for any tail bytes.
  assign exp_beats = {1'b0, size_q >> BPB_LOG2} + (XW+1)'(|(size_q & REM_MASK));

  assign in_xfer   = (state_q == ST_XFER);
  assign beat_fire = in_xfer && rd_tvalid_i && rd_tready_o;

  // Next-state and grant-cycle control.
  always_comb begin
    state_d = state_q;
    ready_c = '0;
    load    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (|req_valid_i) begin
          ready_c = arb_grant;
          load    = 1'b1;
          state_d = ST_START;
        end
      end
      ST_START: state_d = (size_q == '0) ? ST_DONE : ST_XFER;
      ST_XFER:  if (ctrl_rdone_i) state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // The accept pulse is combinational from req_valid_i, so it is gated by
  // rst to keep every output low while reset is held.
  assign req_ready_o = rst ? '0 : ready_c;

  // Stream routing and completion pulse; everything is zero outside XFER/DONE.
  always_comb begin
    req_tvalid_o = '0;
    req_rdone_o  = '0;
    rd_tready_o  = 1'b0;
    if (in_xfer) begin
      req_tvalid_o[grant_q] = rd_tvalid_i;
      rd_tready_o           = req_tready_i[grant_q];
    end
    if (state_q == ST_DONE) req_rdone_o[grant_q] = 1'b1;
  end

  assign req_tdata_o         = in_xfer ? rd_tdata_i : '0;
  assign req_tlast_o         = in_xfer && rd_tlast_i;
  assign ctrl_rstart_o       = (state_q == ST_START) && (size_q != '0);
  assign ctrl_raddr_offset_o = addr_q;
  assign ctrl_rxfer_size_o   = size_q;
  assign err_o               = err_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      grant_q    <= '0;
      rr_ptr_q   <= PTR_W'(NUM_REQ - 1);
      addr_q     <= '0;
      size_q     <= '0;
      beat_cnt_q <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q <= state_d;
      if (load) begin
        grant_q    <= arb_idx;
        addr_q     <= req_addr_i[arb_idx];
        size_q     <= req_size_i[arb_idx];
        beat_cnt_q <= '0;
      end else if (beat_fire) begin
        beat_cnt_q <= beat_cnt_q + 1'b1;
      end
      if (state_q == ST_DONE) begin
        rr_ptr_q <= grant_q;
        if (beat_cnt_q != exp_beats) err_q <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_axim_rd_arbiter.sv
// Bench for axim_rd_arbiter (NUM_REQ = 2, 32-bit address/data/size).
// Inputs change on the falling edge; outputs are sampled 1 ns later.
module tb_axim_rd_arbiter;
  import axim_arb_pkg::*;

  logic              clk;
  logic              rst;
  logic [1:0]        req_valid_i;
  logic [1:0][31:0]  req_addr_i;
  logic [1:0][31:0]  req_size_i;
  logic [1:0]        req_ready_o;
  logic [1:0]        req_tvalid_o;
  logic [31:0]       req_tdata_o;
  logic              req_tlast_o;
  logic [1:0]        req_tready_i;
  logic [1:0]        req_rdone_o;
  logic              err_o;
  logic              ctrl_rstart_o;
  logic [31:0]       ctrl_raddr_offset_o;
  logic [31:0]       ctrl_rxfer_size_o;
  logic              ctrl_rdone_i;
  logic              rd_tvalid_i;
  logic [31:0]       rd_tdata_i;
  logic              rd_tlast_i;
  logic              rd_tready_o;

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] exp_q[$];

  axim_rd_arbiter #(
    .C_M_AXI_ADDR_WIDTH (32),
    .C_M_AXI_DATA_WIDTH (32),
    .C_XFER_SIZE_WIDTH  (32),
    .NUM_REQ            (2)
  ) dut (
    .clk                 (clk),
    .rst                 (rst),
    .req_valid_i         (req_valid_i),
    .req_addr_i          (req_addr_i),
    .req_size_i          (req_size_i),
    .req_ready_o         (req_ready_o),
    .req_tvalid_o        (req_tvalid_o),
    .req_tdata_o         (req_tdata_o),
    .req_tlast_o         (req_tlast_o),
    .req_tready_i        (req_tready_i),
    .req_rdone_o         (req_rdone_o),
    .err_o               (err_o),
    .ctrl_rstart_o       (ctrl_rstart_o),
    .ctrl_raddr_offset_o (ctrl_raddr_offset_o),
    .ctrl_rxfer_size_o   (ctrl_rxfer_size_o),
    .ctrl_rdone_i        (ctrl_rdone_i),
    .rd_tvalid_i         (rd_tvalid_i),
    .rd_tdata_i          (rd_tdata_i),
    .rd_tlast_i          (rd_tlast_i),
    .rd_tready_o         (rd_tready_o)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic clear_inputs();
    req_valid_i  = '0;
    req_addr_i   = '0;
    req_size_i   = '0;
    req_tready_i = '0;
    ctrl_rdone_i = 1'b0;
    rd_tvalid_i  = 1'b0;
    rd_tdata_i   = '0;
    rd_tlast_i   = 1'b0;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ready"},  req_ready_o,         0);
    check({tag, "_tvalid"}, req_tvalid_o,        0);
    check({tag, "_tdata"},  req_tdata_o,         0);
    check({tag, "_tlast"},  req_tlast_o,         0);
    check({tag, "_rdone"},  req_rdone_o,         0);
    check({tag, "_err"},    err_o,               0);
    check({tag, "_rstart"}, ctrl_rstart_o,       0);
    check({tag, "_raddr"},  ctrl_raddr_offset_o, 0);
    check({tag, "_rsize"},  ctrl_rxfer_size_o,   0);
    check({tag, "_tready"}, rd_tready_o,         0);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    clear_inputs();
    rst = 1'b1;
    #1 check_all_zero("reset");
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
  endtask

  // ---------------- scoreboard ----------------
  // Every accepted beat must carry the next queued data word.
  always @(posedge clk) begin
    if (!rst && rd_tvalid_i && rd_tready_o) begin
      if (exp_q.size() == 0) begin
        check("sb_unexpected_beat", 1, 0);
      end else begin
        check("sb_tdata", req_tdata_o, exp_q.pop_front());
      end
    end
  end

  // ---------------- vector table ----------------
  typedef struct {
    logic [1:0]  mask;
    logic [31:0] addr0;
    logic [31:0] addr1;
    logic [31:0] size0;
    logic [31:0] size1;
    int          beats;
    int          exp_grant;
    logic        exp_err;
  } vec_t;

  vec_t vecs[8];

  // One complete transaction: request, START, beats (ctrl_rdone with the
  // last beat), DONE, then an IDLE cycle where err_o is checked.
  task automatic run_xfer(input vec_t v);
    logic [1:0]  oh;
    logic [31:0] sz;
    logic [31:0] ad;
    logic [31:0] d;
    oh = (v.exp_grant == 1) ? 2'b10 : 2'b01;
    sz = (v.exp_grant == 1) ? v.size1 : v.size0;
    ad = (v.exp_grant == 1) ? v.addr1 : v.addr0;

    @(negedge clk);
    req_valid_i   = v.mask;
    req_addr_i[0] = v.addr0;
    req_addr_i[1] = v.addr1;
    req_size_i[0] = v.size0;
    req_size_i[1] = v.size1;
    #1 check("grant_ready", req_ready_o, oh);
    check("idle_tready", rd_tready_o, 0);

    @(negedge clk);
    req_valid_i = '0;
    #1 check("rstart", ctrl_rstart_o, (sz != 0));
    if (sz != 0) begin
      check("raddr", ctrl_raddr_offset_o, ad);
      check("rsize", ctrl_rxfer_size_o, sz);
    end
    check("start_tvalid", req_tvalid_o, 0);

    for (int b = 0; b < v.beats; b++) begin
      @(negedge clk);
      d = $urandom;
      rd_tvalid_i  = 1'b1;
      rd_tdata_i   = d;
      rd_tlast_i   = (b == v.beats - 1);
      req_tready_i = 2'b11;
      ctrl_rdone_i = (b == v.beats - 1);
      exp_q.push_back(d);
      #1 check("beat_tvalid", req_tvalid_o, oh);
      check("beat_tready", rd_tready_o, 1);
      check("beat_tlast", req_tlast_o, (b == v.beats - 1));
    end

    @(negedge clk);
    clear_inputs();
    #1 check("rdone", req_rdone_o, oh);
    check("done_tready", rd_tready_o, 0);

    @(negedge clk);
    #1 check("err_after", err_o, v.exp_err);
    check("rdone_single", req_rdone_o, 0);
  endtask

  // ---------------- test ----------------
  initial begin
    vec_t v;
    int   sent;
    logic [31:0] d;
    logic tr1;

    rst = 1'b1;
    clear_inputs();

    //          mask   addr0     addr1     size0 size1 beats grant err
    vecs[0] = '{2'b11, 32'h100, 32'h200, 32'd16, 32'd8, 4, 0, 1'b0}; // first grant 0
    vecs[1] = '{2'b11, 32'h100, 32'h200, 32'd16, 32'd8, 2, 1, 1'b0}; // then 1
    vecs[2] = '{2'b11, 32'h104, 32'h208, 32'd16, 32'd8, 4, 0, 1'b0}; // then 0
    vecs[3] = '{2'b10, 32'h000, 32'h300, 32'd0,  32'd0, 0, 1, 1'b0}; // zero size
    vecs[4] = '{2'b01, 32'h500, 32'h000, 32'd6,  32'd0, 2, 0, 1'b0}; // 6 B -> 2 beats
    vecs[5] = '{2'b01, 32'h500, 32'h000, 32'd6,  32'd0, 3, 0, 1'b1}; // 3 beats -> err
    vecs[6] = '{2'b10, 32'h000, 32'h600, 32'd0,  32'd5, 2, 1, 1'b1}; // err sticky
    vecs[7] = '{2'b01, 32'h700, 32'h000, 32'd4,  32'd0, 1, 0, 1'b1}; // single beat

    apply_reset();
    for (int i = 0; i < 8; i++) run_xfer(vecs[i]);

    // ---- backpressure on requester 1: tready low for 5 cycles ----
    apply_reset();
    check("err_cleared", err_o, 0);
    @(negedge clk);
    req_valid_i   = 2'b10;
    req_addr_i[1] = 32'h300;
    req_size_i[1] = 32'd16;
    #1 check("bp_ready", req_ready_o, 2'b10);
    @(negedge clk);
    req_valid_i = '0;
    #1 check("bp_rstart", ctrl_rstart_o, 1);
    sent = 0;
    d    = $urandom;
    for (int c = 0; c < 9; c++) begin
      @(negedge clk);
      tr1 = !(c >= 1 && c <= 5);
      rd_tvalid_i  = 1'b1;
      rd_tdata_i   = d;
      rd_tlast_i   = (sent == 3);
      req_tready_i = {tr1, 1'b1};   // requester 0 ready must not leak through
      ctrl_rdone_i = (c == 8);
      #1 check("bp_tready", rd_tready_o, tr1);
      check("bp_tvalid", req_tvalid_o, 2'b10);
      if (tr1) begin
        exp_q.push_back(d);
        sent++;
        d = $urandom;
      end
    end
    @(negedge clk);
    clear_inputs();
    #1 check("bp_rdone", req_rdone_o, 2'b10);
    check("bp_sent", sent, 4);
    @(negedge clk);
    #1 check("bp_err", err_o, 0);

    // ---- reset after 2 of 8 beats ----
    @(negedge clk);
    req_valid_i   = 2'b01;
    req_addr_i[0] = 32'h400;
    req_size_i[0] = 32'd32;
    #1 check("mid_ready", req_ready_o, 2'b01);
    @(negedge clk);
    req_valid_i = '0;
    for (int b = 0; b < 2; b++) begin
      @(negedge clk);
      d = $urandom;
      rd_tvalid_i  = 1'b1;
      rd_tdata_i   = d;
      req_tready_i = 2'b11;
      exp_q.push_back(d);
    end
    @(negedge clk);
    rd_tdata_i = $urandom;
    #1 rst = 1'b1;
    #1 check_all_zero("midrst");
    @(negedge clk);
    clear_inputs();
    rst = 1'b0;
    exp_q.delete();
    @(negedge clk);
    #1 check("midrst_no_rdone", req_rdone_o, 0);

    // ---- ctrl_rdone_i in IDLE is ignored ----
    @(negedge clk);
    ctrl_rdone_i = 1'b1;
    @(negedge clk);
    ctrl_rdone_i = 1'b0;
    #1 check("stray_rdone", req_rdone_o, 0);
    check("stray_rstart", ctrl_rstart_o, 0);

    // ---- after reset, requester 0 wins ----
    v = '{2'b11, 32'h800, 32'h900, 32'd12, 32'd12, 3, 0, 1'b0};
    run_xfer(v);

    @(negedge clk);
    check("sb_drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
